// File: rtl/step_accum_p_if.sv
// Handshake bundle for step_accum_p: command inputs (start, ctrl, step)
// and registered status/result outputs (out, busy, done, ovf).
// master = command source / observer, slave = the accumulator.
interface step_accum_p_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ctrl;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, ctrl, step,
    input  out, busy, done, ovf
  );

  modport slave (
    input  start, ctrl, step,
    output out, busy, done, ovf
  );
endinterface

// File: rtl/step_accum_p.sv
// Sequenced step accumulator: IDLE -> ARM (ARM_CYCLES) -> RUN (RUN_LEN adds/subs) -> DONE.
// Latency: first update ARM_CYCLES+1 edges after start, 1-cycle step-to-out in RUN.
// Backpressure: none; start is a level sampled only in IDLE, all outputs registered.
// Ports: clk, rst (sync, active-high); bus.start/ctrl/step in; bus.out/busy/done/ovf out.
module step_accum_p #(
  parameter int WIDTH      = 8,
  parameter int ARM_CYCLES = 2,
  parameter int RUN_LEN    = 16,
  parameter bit SAT        = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  step_accum_p_if.slave bus
);

  // One spare bit so a counter can hold its terminal value without wrapping.
  localparam int AW = $clog2(ARM_CYCLES) + 1;
  localparam int RW = $clog2(RUN_LEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]    arm_cnt;
  logic [RW-1:0]    run_cnt;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic             arm_last;
  logic             run_last;
  logic [WIDTH:0]   sum;
  logic             evt;
  logic [WIDTH-1:0] acc_nxt;

  assign arm_last = (arm_cnt == AW'(ARM_CYCLES - 1));
  assign run_last = (run_cnt == RW'(RUN_LEN - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ARM;
      S_ARM:   if (arm_last)  state_nxt = S_RUN;
      S_RUN:   if (run_last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // WIDTH+1-bit add/sub; the extra bit is the carry for add overflow.
  // Underflow is judged on the unsigned operands rather than the borrow bit.
  always_comb begin
    sum     = '0;
    evt     = 1'b0;
    acc_nxt = '0;
    if (bus.ctrl) begin
      sum = {1'b0, out_q} - {1'b0, bus.step};
      evt = (out_q < bus.step);
    end else begin
      sum = {1'b0, out_q} + {1'b0, bus.step};
      evt = sum[WIDTH];
    end
    acc_nxt = sum[WIDTH-1:0];
    if (SAT && evt) begin
      acc_nxt = bus.ctrl ? '0 : '1;
    end
  end

  // Datapath, counters and status flags. busy/done are registered from the
  // next state so busy drops on the very edge done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      arm_cnt <= '0;
      run_cnt <= '0;
    end else begin
      busy_q <= (state_nxt == S_ARM) || (state_nxt == S_RUN);
      done_q <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            out_q   <= '0;
            ovf_q   <= 1'b0;
            arm_cnt <= '0;
          end
        end
        S_ARM: begin
          arm_cnt <= arm_cnt + 1'b1;
          if (arm_last) begin
            run_cnt <= '0;
          end
        end
        S_RUN: begin
          out_q   <= acc_nxt;
          ovf_q   <= ovf_q | evt;
          run_cnt <= run_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_step_accum_p.sv
// Bench for step_accum_p: two WIDTH=4/ARM=2/RUN=4 instances (wrap and saturate)
// share one table of per-edge stimulus and expected outputs; a third
// instance with ARM=1/RUN=1 checks minimum start-to-done latency.
module tb_step_accum_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_accum_p_if #(.WIDTH(4)) b0 ();
  step_accum_p_if #(.WIDTH(4)) b1 ();
  step_accum_p_if #(.WIDTH(4)) b2 ();

  step_accum_p #(.WIDTH(4), .ARM_CYCLES(2), .RUN_LEN(4), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(b0.slave));
  step_accum_p #(.WIDTH(4), .ARM_CYCLES(2), .RUN_LEN(4), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(b1.slave));
  step_accum_p #(.WIDTH(4), .ARM_CYCLES(1), .RUN_LEN(1), .SAT(1'b0)) u_min (
    .clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    logic       r;
    logic       s;
    logic       c;
    logic [3:0] st;
    logic [3:0] o0;
    logic [3:0] o1;
    logic       b;
    logic       d;
    logic       v;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic r, input logic s, input logic c, input logic [3:0] st,
                     input logic [3:0] o0, input logic [3:0] o1,
                     input logic b, input logic d, input logic v);
    vec_t t;
    t.r = r; t.s = s; t.c = c; t.st = st;
    t.o0 = o0; t.o1 = o1; t.b = b; t.d = d; t.v = v;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, act, exp);
    end
  endtask

  initial begin
    int n;
    b0.start = 1'b0; b0.ctrl = 1'b0; b0.step = '0;
    b1.start = 1'b0; b1.ctrl = 1'b0; b1.step = '0;
    b2.start = 1'b0; b2.ctrl = 1'b0; b2.step = '0;

    //   rst st  c  step  o0  o1  busy done ovf
    add(1, 1, 0, 0,   0,  0,  0, 0, 0);   // reset holds with start high
    add(1, 1, 0, 0,   0,  0,  0, 0, 0);
    add(0, 1, 0, 0,   0,  0,  1, 0, 0);   // start edge -> ARM
    add(0, 1, 1, 9,   0,  0,  1, 0, 0);   // ARM: start/step ignored
    add(0, 0, 0, 9,   0,  0,  1, 0, 0);   // ARM -> RUN
    add(0, 1, 0, 3,   3,  3,  1, 0, 0);   // add run, start toggled in RUN
    add(0, 0, 0, 3,   6,  6,  1, 0, 0);
    add(0, 1, 0, 3,   9,  9,  1, 0, 0);
    add(0, 0, 0, 3,  12, 12,  0, 1, 0);   // last update, done
    add(0, 0, 0, 3,  12, 12,  0, 0, 0);   // idle
    add(0, 1, 0, 0,   0,  0,  1, 0, 0);   // wrap/sat run
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 5,   5,  5,  1, 0, 0);
    add(0, 0, 0, 5,  10, 10,  1, 0, 0);
    add(0, 0, 0, 5,  15, 15,  1, 0, 0);
    add(0, 1, 0, 5,   4, 15,  0, 1, 1);   // overflow, start held into DONE
    add(0, 1, 0, 0,   4, 15,  0, 0, 1);   // single idle cycle
    add(0, 1, 0, 0,   0,  0,  1, 0, 0);   // re-arm clears out/ovf
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 4,   4,  4,  1, 0, 0);   // direction mix
    add(0, 0, 1, 2,   2,  2,  1, 0, 0);
    add(0, 0, 1, 7,  11,  0,  1, 0, 1);   // underflow
    add(0, 0, 0, 1,  12,  1,  0, 1, 1);
    add(0, 0, 0, 0,  12,  1,  0, 0, 1);
    add(0, 1, 0, 0,   0,  0,  1, 0, 0);   // new start clears ovf
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 1, 9,   7,  0,  1, 0, 1);   // 1st RUN cycle, underflow
    add(1, 0, 0, 9,   0,  0,  0, 0, 0);   // reset in 2nd RUN cycle
    add(0, 0, 0, 9,   0,  0,  0, 0, 0);   // no done pulse
    add(0, 0, 0, 0,   0,  0,  0, 0, 0);
    add(0, 1, 0, 0,   0,  0,  1, 0, 0);   // full normal run afterwards
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 0,   0,  0,  1, 0, 0);
    add(0, 0, 0, 1,   1,  1,  1, 0, 0);
    add(0, 0, 0, 1,   2,  2,  1, 0, 0);
    add(0, 0, 0, 1,   3,  3,  1, 0, 0);
    add(0, 0, 0, 1,   4,  4,  0, 1, 0);
    add(0, 0, 0, 0,   4,  4,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst      = vecs[i].r;
      b0.start = vecs[i].s; b0.ctrl = vecs[i].c; b0.step = vecs[i].st;
      b1.start = vecs[i].s; b1.ctrl = vecs[i].c; b1.step = vecs[i].st;
      @(posedge clk);
      #1;
      chk("wrap_out",  i, 8'(b0.out),  8'(vecs[i].o0));
      chk("sat_out",   i, 8'(b1.out),  8'(vecs[i].o1));
      chk("wrap_busy", i, 8'(b0.busy), 8'(vecs[i].b));
      chk("sat_busy",  i, 8'(b1.busy), 8'(vecs[i].b));
      chk("wrap_done", i, 8'(b0.done), 8'(vecs[i].d));
      chk("sat_done",  i, 8'(b1.done), 8'(vecs[i].d));
      chk("wrap_ovf",  i, 8'(b0.ovf),  8'(vecs[i].v));
      chk("sat_ovf",   i, 8'(b1.ovf),  8'(vecs[i].v));
    end

    // Minimum-latency instance: ARM=1, RUN=1, done in the 2nd cycle after start edge.
    @(negedge clk);
    b2.start = 1'b1; b2.step = 4'd7; b2.ctrl = 1'b0;
    @(posedge clk);
    #1;
    chk("min_busy_start", 0, 8'(b2.busy), 8'd1);
    chk("min_out_start",  0, 8'(b2.out),  8'd0);
    @(negedge clk);
    b2.start = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (b2.done === 1'b1) break;
    end
    chk("min_done_latency", 0, 8'(n), 8'd2);
    chk("min_done_out",     0, 8'(b2.out),  8'd7);
    chk("min_done_busy",    0, 8'(b2.busy), 8'd0);
    @(posedge clk);
    #1;
    chk("min_done_width",   0, 8'(b2.done), 8'd0);
    chk("min_idle_busy",    0, 8'(b2.busy), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
